// File: rtl/llc_controller.sv
// ============================================================================
// llc_controller
//   Behavioural last-level cache for one processor on a shared snooping bus.
//   The cache is 16-way set-associative and write-allocate, keeps lines in
//   MESI states and picks victims with a per-set tree pseudo-LRU. Each clock
//   it consumes one trace command: an L1 request, a snooped bus operation,
//   a clear or a print.
//
//   Ports
//     clk, rst_n        rising-edge clock, asynchronous active-low reset
//     addr, op          command byte address and trace op code
//     cacheRds/Wrs      L1 read (ops 0,2) and write (op 1) counts
//     cacheHits/Misses  hit and miss counts over ops 0-2
//     busOp             our own bus operation for this cycle
//     snoopResult       reply to a snooped op, or the other caches' reply
//                       to our own READ/RWIM
//     message           message to L1
//     LLC_cache         live tag/state array {valid, tag, mesi}
//     hold              1 = command needs a second cycle, keep op/addr
//
//   Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package llc_pkg;
  localparam int NUM_SETS      = 16384;
  localparam int ASSOCIATIVITY = 16;
  localparam int LINE_BYTES    = 64;
  localparam int OFFSET_W      = $clog2(LINE_BYTES);
  localparam int SET_W         = $clog2(NUM_SETS);
  localparam int TAG_W         = 32 - SET_W - OFFSET_W;

  typedef enum logic [1:0] {I = 2'd0, S = 2'd1, E = 2'd2, M = 2'd3} mesi_t;
  typedef enum logic [2:0] {NOBUSOP, READ, WRITE, INVALIDATE, RWIM} busop_t;
  typedef enum logic [1:0] {NORESULT, HIT, HITM, NOHIT} snoop_t;
  typedef enum logic [2:0] {NOMESSAGE, GETLINE, SENDLINE, INVALIDATELINE, EVICTLINE} msg_t;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    mesi_t            mesi;
  } line_t;
endpackage

module llc_controller
  import llc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] op,
  output logic [31:0] cacheRds,
  output logic [31:0] cacheWrs,
  output logic [31:0] cacheHits,
  output logic [31:0] cacheMisses,
  output busop_t      busOp,
  output snoop_t      snoopResult,
  output msg_t        message,
  output line_t       LLC_cache [NUM_SETS][ASSOCIATIVITY],
  output logic [31:0] hold
);

  localparam int WAY_W     = $clog2(ASSOCIATIVITY);
  localparam int PLRU_BITS = ASSOCIATIVITY - 1;
  localparam int NODE_W    = $clog2(PLRU_BITS);

  // Two-cycle commands (eviction, snooped RWIM on a modified line) park in
  // ST_SECOND between their two cycles.
  typedef enum logic {ST_FIRST = 1'b0, ST_SECOND = 1'b1} phase_t;

  phase_t                 state_q, state_d;
  busop_t                 bus_q, bus_d;
  snoop_t                 snoop_q, snoop_d;
  msg_t                   msg_q, msg_d;
  logic                   hold_q, hold_d;
  logic [31:0]            rds_q, rds_d, wrs_q, wrs_d, hits_q, hits_d, misses_q, misses_d;
  logic [PLRU_BITS-1:0]   plru_q [NUM_SETS];

  logic [SET_W-1:0]       set_idx;
  logic [TAG_W-1:0]       tag;
  logic                   hit, inv_found, is_write, count_access, clear;
  logic [WAY_W-1:0]       hit_way, inv_way, fill_way;
  line_t                  hit_line, victim_line, cache_line;
  logic [WAY_W-1:0]       cache_way;
  logic                   cache_we, plru_we;
  logic [PLRU_BITS-1:0]   plru_cur, plru_new;
  snoop_t                 emu;
  logic                   unused_addr;

  assign set_idx     = addr[OFFSET_W +: SET_W];
  assign tag         = addr[31 -: TAG_W];
  assign is_write    = (op == 32'd1);
  assign unused_addr = ^addr[OFFSET_W-1:2];
  assign plru_cur    = plru_q[set_idx];

  // Tree layout: node n has children 2n+1 (left, lower ways) and 2n+2.
  // A bit of 0 sends the victim search left.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_BITS-1:0] bits);
    logic [NODE_W-1:0] node;
    logic [WAY_W-1:0]  way;
    node = '0;
    way  = '0;
    for (int lvl = 0; lvl < WAY_W; lvl++) begin
      way  = {way[WAY_W-2:0], bits[node]};
      node = NODE_W'((node << 1) + NODE_W'(1) + NODE_W'(bits[node]));
    end
    return way;
  endfunction

  // Point every node on the path away from the touched way.
  function automatic logic [PLRU_BITS-1:0] plru_touch(input logic [PLRU_BITS-1:0] bits,
                                                      input logic [WAY_W-1:0]     way);
    logic [NODE_W-1:0]    node;
    logic [PLRU_BITS-1:0] nb;
    logic [WAY_W-1:0]     w;
    logic                 dir;
    node = '0;
    nb   = bits;
    w    = way;
    for (int lvl = 0; lvl < WAY_W; lvl++) begin
      dir      = w[WAY_W-1];
      nb[node] = ~dir;
      node     = NODE_W'((node << 1) + NODE_W'(1) + NODE_W'(dir));
      w        = w << 1;
    end
    return nb;
  endfunction

  // Tag lookup; scanning downward leaves the lowest invalid way selected.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = ASSOCIATIVITY - 1; w >= 0; w--) begin
      if (LLC_cache[set_idx][w].valid && (LLC_cache[set_idx][w].mesi != I) &&
          (LLC_cache[set_idx][w].tag == tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!LLC_cache[set_idx][w].valid || (LLC_cache[set_idx][w].mesi == I)) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
  end

  assign fill_way    = inv_found ? inv_way : plru_victim(plru_cur);
  assign hit_line    = LLC_cache[set_idx][hit_way];
  assign victim_line = LLC_cache[set_idx][fill_way];

  // Other caches' reply to our READ/RWIM, emulated from the low address bits.
  always_comb begin
    if (addr[1])      emu = NOHIT;
    else if (addr[0]) emu = HITM;
    else              emu = HIT;
  end

  always_comb begin
    state_d      = ST_FIRST;
    bus_d        = NOBUSOP;
    snoop_d      = NORESULT;
    msg_d        = NOMESSAGE;
    hold_d       = 1'b0;
    rds_d        = rds_q;
    wrs_d        = wrs_q;
    hits_d       = hits_q;
    misses_d     = misses_q;
    cache_we     = 1'b0;
    cache_way    = hit_way;
    cache_line   = hit_line;
    plru_we      = 1'b0;
    plru_new     = plru_touch(plru_cur, hit_way);
    count_access = 1'b0;
    clear        = 1'b0;

    case (op)
      32'd0, 32'd1, 32'd2: begin
        if (hit) begin
          count_access = 1'b1;
          hits_d       = hits_q + 32'd1;
          plru_we      = 1'b1;
          if (!is_write) begin
            msg_d = SENDLINE;
          end else begin
            case (hit_line.mesi)
              S: begin
                bus_d           = INVALIDATE;
                cache_we        = 1'b1;
                cache_line.mesi = M;
              end
              E: begin
                cache_we        = 1'b1;
                cache_line.mesi = M;
              end
              default: ;
            endcase
          end
        end else if (!inv_found && (state_q == ST_FIRST)) begin
          // Set is full: write back / drop the victim before the fill.
          state_d = ST_SECOND;
          hold_d  = 1'b1;
          msg_d   = EVICTLINE;
          if (victim_line.mesi == M) bus_d = WRITE;
        end else begin
          count_access     = 1'b1;
          misses_d         = misses_q + 32'd1;
          cache_we         = 1'b1;
          cache_way        = fill_way;
          cache_line.valid = 1'b1;
          cache_line.tag   = tag;
          if (is_write)            cache_line.mesi = M;
          else if (emu == NOHIT)   cache_line.mesi = E;
          else                     cache_line.mesi = S;
          bus_d            = is_write ? RWIM : READ;
          snoop_d          = emu;
          msg_d            = SENDLINE;
          plru_we          = 1'b1;
          plru_new         = plru_touch(plru_cur, fill_way);
        end
      end

      32'd3: begin
        if (hit) begin
          snoop_d         = (hit_line.mesi == M) ? HITM : HIT;
          if (hit_line.mesi == M) begin
            bus_d = WRITE;
            msg_d = GETLINE;
          end
          cache_we        = 1'b1;
          cache_line.mesi = S;
        end else begin
          snoop_d = NOHIT;
        end
      end

      32'd5: begin
        if (hit) begin
          if ((hit_line.mesi == M) && (state_q == ST_FIRST)) begin
            state_d = ST_SECOND;
            hold_d  = 1'b1;
            snoop_d = HITM;
            bus_d   = WRITE;
            msg_d   = GETLINE;
          end else begin
            if (hit_line.mesi != M) snoop_d = HIT;
            msg_d            = INVALIDATELINE;
            cache_we         = 1'b1;
            cache_line.valid = 1'b0;
            cache_line.mesi  = I;
          end
        end else begin
          snoop_d = NOHIT;
        end
      end

      32'd6: begin
        if (hit && (hit_line.mesi == S)) begin
          snoop_d          = HIT;
          msg_d            = INVALIDATELINE;
          cache_we         = 1'b1;
          cache_line.valid = 1'b0;
          cache_line.mesi  = I;
        end
      end

      32'd8: clear = 1'b1;

      default: ;
    endcase

    if (count_access) begin
      if (is_write) wrs_d = wrs_q + 32'd1;
      else          rds_d = rds_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_FIRST;
      bus_q    <= NOBUSOP;
      snoop_q  <= NORESULT;
      msg_q    <= NOMESSAGE;
      hold_q   <= 1'b0;
      rds_q    <= '0;
      wrs_q    <= '0;
      hits_q   <= '0;
      misses_q <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        plru_q[s] <= '0;
        for (int w = 0; w < ASSOCIATIVITY; w++) LLC_cache[s][w] <= '{1'b0, '0, I};
      end
    end else if (clear) begin
      state_q  <= ST_FIRST;
      bus_q    <= NOBUSOP;
      snoop_q  <= NORESULT;
      msg_q    <= NOMESSAGE;
      hold_q   <= 1'b0;
      rds_q    <= '0;
      wrs_q    <= '0;
      hits_q   <= '0;
      misses_q <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        plru_q[s] <= '0;
        for (int w = 0; w < ASSOCIATIVITY; w++) LLC_cache[s][w] <= '{1'b0, '0, I};
      end
    end else begin
      state_q  <= state_d;
      bus_q    <= bus_d;
      snoop_q  <= snoop_d;
      msg_q    <= msg_d;
      hold_q   <= hold_d;
      rds_q    <= rds_d;
      wrs_q    <= wrs_d;
      hits_q   <= hits_d;
      misses_q <= misses_d;
      if (cache_we) LLC_cache[set_idx][cache_way] <= cache_line;
      if (plru_we)  plru_q[set_idx] <= plru_new;
    end
  end

  assign busOp       = bus_q;
  assign snoopResult = snoop_q;
  assign message     = msg_q;
  assign hold        = {31'd0, hold_q};
  assign cacheRds    = rds_q;
  assign cacheWrs    = wrs_q;
  assign cacheHits   = hits_q;
  assign cacheMisses = misses_q;

endmodule

`default_nettype wire

// File: tb/tb_llc_controller.sv
// ============================================================================
// tb_llc_controller
//   Self-checking bench for llc_controller: directed scenarios followed by
//   randomized traffic, compared against a behavioural cache model that
//   tracks per-way last-use times instead of a PLRU bit tree.
//   Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_llc_controller;
  import llc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] tb_addr = '0;
  logic [31:0] tb_op = 32'd9;
  logic [31:0] cacheRds, cacheWrs, cacheHits, cacheMisses, hold;
  busop_t      busOp;
  snoop_t      snoopResult;
  msg_t        message;
  line_t       llc [NUM_SETS][ASSOCIATIVITY];

  llc_controller dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .addr        (tb_addr),
    .op          (tb_op),
    .cacheRds    (cacheRds),
    .cacheWrs    (cacheWrs),
    .cacheHits   (cacheHits),
    .cacheMisses (cacheMisses),
    .busOp       (busOp),
    .snoopResult (snoopResult),
    .message     (message),
    .LLC_cache   (llc),
    .hold        (hold)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit          mv [NUM_SETS][ASSOCIATIVITY];
  bit [11:0]   mt [NUM_SETS][ASSOCIATIVITY];
  mesi_t       ms [NUM_SETS][ASSOCIATIVITY];
  int unsigned mu [NUM_SETS][ASSOCIATIVITY];   // last-use time, 0 = never
  int unsigned tick = 0;
  int unsigned c_rd, c_wr, c_hit, c_miss;

  task automatic model_clear();
    for (int s = 0; s < NUM_SETS; s++)
      for (int w = 0; w < ASSOCIATIVITY; w++) begin
        mv[s][w] = 1'b0; mt[s][w] = '0; ms[s][w] = I; mu[s][w] = 0;
      end
    c_rd = 0; c_wr = 0; c_hit = 0; c_miss = 0;
  endtask

  task automatic touch(input int s, input int w);
    tick++;
    mu[s][w] = tick;
  endtask

  // Binary halving: go to the half whose most recent use is older.
  function automatic int pick(input int s);
    int lo, hi, mid;
    int unsigned ml, mr;
    lo = 0; hi = ASSOCIATIVITY;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      ml = 0; mr = 0;
      for (int k = lo; k < mid; k++) if (mu[s][k] > ml) ml = mu[s][k];
      for (int k = mid; k < hi; k++) if (mu[s][k] > mr) mr = mu[s][k];
      if (ml > mr) lo = mid; else hi = mid;
    end
    return lo;
  endfunction

  task automatic model_cmd(input int unsigned o, input logic [31:0] a, input bit second,
                           output busop_t eb, output snoop_t es, output msg_t em, output bit eh);
    int s, hw, vw;
    logic [11:0] t;
    snoop_t reply;
    bit wr;
    s = int'(a[19:6]); t = a[31:20]; hw = -1; vw = -1;
    eb = NOBUSOP; es = NORESULT; em = NOMESSAGE; eh = 1'b0;
    for (int w = 0; w < ASSOCIATIVITY; w++) if (mv[s][w] && mt[s][w] == t) hw = w;
    reply = a[1] ? NOHIT : (a[0] ? HITM : HIT);
    wr = (o == 1);
    if (o <= 2) begin
      if (hw >= 0) begin
        if (wr) c_wr++; else c_rd++;
        c_hit++;
        touch(s, hw);
        if (!wr) em = SENDLINE;
        else begin
          if (ms[s][hw] == S) eb = INVALIDATE;
          ms[s][hw] = M;
        end
      end else begin
        for (int w = ASSOCIATIVITY - 1; w >= 0; w--) if (!mv[s][w]) vw = w;
        if (vw < 0) vw = pick(s);
        if (mv[s][vw] && !second) begin
          eh = 1'b1; em = EVICTLINE;
          if (ms[s][vw] == M) eb = WRITE;
        end else begin
          if (wr) c_wr++; else c_rd++;
          c_miss++;
          eb = wr ? RWIM : READ; es = reply; em = SENDLINE;
          mv[s][vw] = 1'b1; mt[s][vw] = t;
          ms[s][vw] = wr ? M : ((reply == NOHIT) ? E : S);
          touch(s, vw);
        end
      end
    end else if (o == 3) begin
      if (hw >= 0) begin
        if (ms[s][hw] == M) begin es = HITM; eb = WRITE; em = GETLINE; end
        else es = HIT;
        ms[s][hw] = S;
      end else es = NOHIT;
    end else if (o == 5) begin
      if (hw >= 0) begin
        if (ms[s][hw] == M && !second) begin
          eh = 1'b1; es = HITM; eb = WRITE; em = GETLINE;
        end else begin
          if (ms[s][hw] != M) es = HIT;
          em = INVALIDATELINE; mv[s][hw] = 1'b0; ms[s][hw] = I;
        end
      end else es = NOHIT;
    end else if (o == 6) begin
      if (hw >= 0 && ms[s][hw] == S) begin
        es = HIT; em = INVALIDATELINE; mv[s][hw] = 1'b0; ms[s][hw] = I;
      end
    end else if (o == 8) begin
      model_clear();
    end
  endtask

  function automatic logic [14:0] dut_line(input int s, input int w);
    line_t l;
    l = llc[s][w];
    if (l.valid) return l;
    return {1'b0, 12'h0, l.mesi};
  endfunction

  function automatic logic [14:0] mdl_line(input int s, input int w);
    if (mv[s][w]) return {1'b1, mt[s][w], ms[s][w]};
    return {1'b0, 12'h0, I};
  endfunction

  task automatic check_outputs(input string ctx, input logic [31:0] a, input busop_t eb,
                               input snoop_t es, input msg_t em, input bit eh);
    int s;
    s = int'(a[19:6]);
    check_val({ctx, " busOp"}, busOp, eb);
    check_val({ctx, " snoopResult"}, snoopResult, es);
    check_val({ctx, " message"}, message, em);
    check_val({ctx, " hold"}, hold, {31'd0, eh});
    check_val({ctx, " cacheRds"}, cacheRds, c_rd);
    check_val({ctx, " cacheWrs"}, cacheWrs, c_wr);
    check_val({ctx, " cacheHits"}, cacheHits, c_hit);
    check_val({ctx, " cacheMisses"}, cacheMisses, c_miss);
    for (int w = 0; w < ASSOCIATIVITY; w++)
      check_val($sformatf("%s line[%0d][%0d]", ctx, s, w), dut_line(s, w), mdl_line(s, w));
  endtask

  // Drive one command, following it through a second cycle when the model
  // expects hold. first_hold returns the DUT hold seen in the first cycle.
  task automatic run_cmd(input int unsigned o, input logic [31:0] a, output logic [31:0] first_hold);
    busop_t eb; snoop_t es; msg_t em; bit eh;
    string ctx;
    ctx = $sformatf("op=%0d addr=%h", o, a);
    tb_op = o; tb_addr = a;
    model_cmd(o, a, 1'b0, eb, es, em, eh);
    @(posedge clk); #1;
    first_hold = hold;
    check_outputs({ctx, " c1"}, a, eb, es, em, eh);
    if (eh) begin
      model_cmd(o, a, 1'b1, eb, es, em, eh);
      @(posedge clk); #1;
      check_outputs({ctx, " c2"}, a, eb, es, em, eh);
    end
  endtask

  function automatic logic [31:0] mk_addr(input int t, input int s, input int lo);
    return {12'(t), 14'(s), 6'(lo)};
  endfunction

  initial begin
    logic [31:0] fh, a;
    busop_t eb; snoop_t es; msg_t em; bit eh;
    int nv, r, sel;
    int unsigned o;

    // Reset state
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_val("reset busOp", busOp, NOBUSOP);
    check_val("reset snoopResult", snoopResult, NORESULT);
    check_val("reset message", message, NOMESSAGE);
    check_val("reset hold", hold, 0);
    check_val("reset cacheRds", cacheRds, 0);
    check_val("reset cacheMisses", cacheMisses, 0);
    check_val("reset line valid", llc[0][0].valid, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // T1: read miss, emulated NOHIT -> E
    run_cmd(0, 32'h0000_0002, fh);
    check_val("T1 busOp", busOp, READ);
    check_val("T1 snoop", snoopResult, NOHIT);
    check_val("T1 mesi", llc[0][0].mesi, E);
    check_val("T1 rds", cacheRds, 1);
    check_val("T1 misses", cacheMisses, 1);

    // T2: read hit, then write hit on E -> M silently
    run_cmd(0, 32'h0000_0002, fh);
    check_val("T2 hits", cacheHits, 1);
    check_val("T2 message", message, SENDLINE);
    run_cmd(1, 32'h0000_0002, fh);
    check_val("T2 wr busOp", busOp, NOBUSOP);
    check_val("T2 mesi", llc[0][0].mesi, M);
    check_val("T2 wrs", cacheWrs, 1);

    // T3: instruction read with HIT reply -> S, then write -> INVALIDATE, M
    run_cmd(2, 32'h1000_0000, fh);
    check_val("T3 busOp", busOp, READ);
    check_val("T3 mesi", llc[0][1].mesi, S);
    run_cmd(1, 32'h1000_0000, fh);
    check_val("T3 wr busOp", busOp, INVALIDATE);
    check_val("T3 wr mesi", llc[0][1].mesi, M);

    // T4: 17 writes into set 0; the 17th evicts the LRU modified line (tag 0)
    run_cmd(8, 32'h0, fh);
    for (int t = 0; t < 16; t++) run_cmd(1, mk_addr(t, 0, 2), fh);
    run_cmd(1, mk_addr(16, 0, 2), fh);
    check_val("T4 first hold", fh, 1);
    check_val("T4 fill busOp", busOp, RWIM);
    check_val("T4 victim tag", llc[0][0].tag, 16);
    check_val("T4 misses", cacheMisses, 17);

    // T5: snoops on modified, shared and absent lines
    run_cmd(3, mk_addr(5, 0, 0), fh);
    check_val("T5 snoop read", snoopResult, HITM);
    check_val("T5 mesi S", llc[0][5].mesi, S);
    run_cmd(6, mk_addr(5, 0, 0), fh);
    check_val("T5 inval msg", message, INVALIDATELINE);
    check_val("T5 inval valid", llc[0][5].valid, 0);
    run_cmd(5, mk_addr(100, 0, 0), fh);
    check_val("T5 rwim miss", snoopResult, NOHIT);
    run_cmd(5, mk_addr(6, 0, 0), fh);
    check_val("T5 rwim M hold", fh, 1);
    check_val("T5 rwim M valid", llc[0][6].valid, 0);

    // Reset during the first cycle of an eviction aborts it
    run_cmd(8, 32'h0, fh);
    for (int t = 0; t < 16; t++) run_cmd(1, mk_addr(t, 2, 3), fh);
    a = mk_addr(40, 2, 3);
    tb_op = 0; tb_addr = a;
    model_cmd(0, a, 1'b0, eb, es, em, eh);
    @(posedge clk); #1;
    check_outputs("abort c1", a, eb, es, em, eh);
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    check_val("abort hold", hold, 0);
    check_val("abort message", message, NOMESSAGE);
    check_val("abort wrs", cacheWrs, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_cmd(9, a, fh);
    run_cmd(0, a, fh);
    check_val("abort refill hold", fh, 0);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 99);
      if      (r < 25) o = 0;
      else if (r < 45) o = 1;
      else if (r < 55) o = 2;
      else if (r < 65) o = 3;
      else if (r < 70) o = 4;
      else if (r < 78) o = 5;
      else if (r < 86) o = 6;
      else if (r < 88) o = 7;
      else if (r < 90) o = $urandom_range(10, 1000);
      else if (r < 99) o = 9;
      else             o = 8;
      sel = $urandom_range(0, 3);
      a = mk_addr($urandom_range(0, 19), (sel == 3) ? 16383 : sel, $urandom_range(0, 63));
      run_cmd(o, a, fh);
    end

    // T6: clear wipes everything; print does nothing
    run_cmd(8, 32'h0, fh);
    check_val("T6 rds", cacheRds, 0);
    check_val("T6 hits", cacheHits, 0);
    nv = 0;
    for (int s = 0; s < NUM_SETS; s++)
      for (int w = 0; w < ASSOCIATIVITY; w++) nv += int'(llc[s][w].valid);
    check_val("T6 valid count", nv, 0);
    run_cmd(9, 32'h0000_0001, fh);
    check_val("T6 print busOp", busOp, NOBUSOP);
    check_val("T6 print snoop", snoopResult, NORESULT);
    check_val("T6 print message", message, NOMESSAGE);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
